sega_joy_scanner: RTL

//  Sequences the shared DB9 joystick select line (joyX_p7_o) and scans both ports for

---
 rtl/sega_joy_scanner.sv | 127 ++++++++++++
 1 files changed

// File: rtl/sega_joy_scanner.sv
// DB9 joystick scanner: drives the shared select line (pin 7) through a fixed
// per-frame sequence and assembles active-low 12-bit button words for two
// ports. The words cover Atari/SMS pads and Mega Drive 3- and 6-button pads.
module sega_joy_scanner #(
  parameter int STEP_DIV = 1536,
  parameter int SEQ_LEN  = 256
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [5:0]  joy1_i,
  input  logic [5:0]  joy2_i,
  output logic        joy_p7_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        six1_o,
  output logic        six2_o,
  output logic        frame_o
);

  localparam int DIV_W = $clog2(STEP_DIV);
  localparam int PH_W  = $clog2(SEQ_LEN);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SEQ_LEN - 1);

  logic [DIV_W-1:0] div_reg, div_next;
  logic [PH_W-1:0]  phase_reg, phase_next;
  logic             p7_reg, p7_next;
  logic             frame_reg, frame_next;
  logic             tick;

  // Per-port buses so both ports come out of one generate loop
  logic [5:0]  pins_in [2];
  logic [11:0] word_out [2];
  logic        six_out [2];

  assign pins_in[0] = joy1_i;
  assign pins_in[1] = joy2_i;

  assign tick = (div_reg == DIV_LAST);

  // Step divider, phase counter and select-line pattern for the next step
  always_comb begin
    div_next   = tick ? '0 : div_reg + 1'b1;
    phase_next = phase_reg;
    p7_next    = p7_reg;
    frame_next = 1'b0;
    if (tick) begin
      phase_next = (phase_reg == PH_LAST) ? '0 : phase_reg + 1'b1;
      frame_next = (phase_reg == PH_W'(6));
      case (phase_reg)
        PH_W'(0), PH_W'(2), PH_W'(4), PH_W'(6): p7_next = 1'b0;
        default:                                p7_next = 1'b1;
      endcase
    end
  end

  // Sequencer state register; reset restarts the scan from phase 0
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div_reg   <= '0;
      phase_reg <= '0;
      p7_reg    <= 1'b1;
      frame_reg <= 1'b0;
    end else begin
      div_reg   <= div_next;
      phase_reg <= phase_next;
      p7_reg    <= p7_next;
      frame_reg <= frame_next;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic [5:0]  sync1_reg, sync2_reg;
    logic [11:0] sh_reg, word_reg;
    logic        six_det_reg, six_reg;
    logic [3:0]  ext_bits;

    // Extra buttons {M,X,Y,Z} only exist on a pad identified as 6-button
    assign ext_bits = six_det_reg ? sync2_reg[3:0] : 4'hF;

    // Synchronise pins, build the shadow word, publish it in one step at phase 6
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        sync1_reg   <= 6'h3F;
        sync2_reg   <= 6'h3F;
        sh_reg      <= 12'hFFF;
        word_reg    <= 12'hFFF;
        six_det_reg <= 1'b0;
        six_reg     <= 1'b0;
      end else begin
        sync1_reg <= pins_in[gi];
        sync2_reg <= sync1_reg;
        if (tick) begin
          case (phase_reg)
            PH_W'(2): begin
              sh_reg[5:0] <= sync2_reg;
              six_det_reg <= 1'b0;
            end
            PH_W'(3): begin
              // Right and left both low with select low means a Mega Drive pad
              if (sync2_reg[3:2] == 2'b00) sh_reg[7:6] <= sync2_reg[5:4];
              else                         sh_reg[7:4] <= {2'b11, sync2_reg[5:4]};
            end
            PH_W'(5): six_det_reg <= (sync2_reg[3:0] == 4'h0);
            PH_W'(6): begin
              sh_reg[11:8] <= ext_bits;
              word_reg     <= {ext_bits, sh_reg[7:0]};
              six_reg      <= six_det_reg;
            end
            default: ;
          endcase
        end
      end
    end

    assign word_out[gi] = word_reg;
    assign six_out[gi]  = six_reg;
  end

  assign joy_p7_o = p7_reg;
  assign frame_o  = frame_reg;
  assign joy1_o   = word_out[0];
  assign joy2_o   = word_out[1];
  assign six1_o   = six_out[0];
  assign six2_o   = six_out[1];

endmodule
